// File: rtl/sga_sensor_scheduler.sv
// Sequences the left/right ultrasonic interfaces and turns debounced proximity verdicts
// into the 2-bit snake direction. Optional turn lock: define SGA_TURN_LOCK_EN.
module sga_sensor_scheduler #(
    parameter int PERIOD  = 400000,
    parameter int TIMEOUT = 2000000,
    parameter int CONFIRM = 2
) (
    input  logic       clock,
    input  logic       restart,
    input  logic       enable,
    input  logic       clear_dir,
    input  logic       move_tick,
    input  logic       pronto_esq,
    input  logic       pronto_dir,
    input  logic       esq,
    input  logic       dir,
    output logic       medir,
    output logic       reset_interface,
    output logic [1:0] direction,
    output logic       turned,
    output logic [3:0] timeout_count,
    output logic [2:0] db_estado
);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_MEDIR     = 3'd1,
        ST_ESPERA    = 3'd2,
        ST_AVALIA    = 3'd3,
        ST_INTERVALO = 3'd4,
        ST_FALHA     = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        VERD_NONE  = 2'd0,
        VERD_LEFT  = 2'd1,
        VERD_RIGHT = 2'd2
    } verdict_t;

    localparam logic [25:0] PERIOD_LAST  = 26'(PERIOD - 1);
    localparam logic [25:0] TIMEOUT_LAST = 26'(TIMEOUT - 1);
    localparam logic [2:0]  CONFIRM_MIN  = 3'(CONFIRM);

    state_t      state_reg, state_next;
    logic [25:0] timer_reg, timer_next;
    logic        got_esq_reg, got_esq_next;
    logic        got_dir_reg, got_dir_next;
    logic [2:0]  confirm_reg, confirm_next, confirm_eval;
    verdict_t    prev_reg, prev_next, verdict;
    logic [1:0]  direction_reg, direction_next;
    logic [3:0]  timeouts_reg, timeouts_next;
    logic        medir_reg, medir_next;
    logic        reset_if_reg, reset_if_next;
    logic        turned_reg, turn;
    logic        armed;
    logic        both_seen;

    // Pulses arriving this cycle count together with the sticky flags.
    assign both_seen = (got_esq_reg | pronto_esq) & (got_dir_reg | pronto_dir);

    always_comb begin
        verdict = VERD_NONE;
        if (esq && !dir) begin
            verdict = VERD_LEFT;
        end else if (dir && !esq) begin
            verdict = VERD_RIGHT;
        end
        if (verdict == VERD_NONE || verdict != prev_reg) begin
            confirm_eval = (verdict != VERD_NONE) ? 3'd1 : 3'd0;
        end else begin
            confirm_eval = (confirm_reg == 3'd7) ? 3'd7 : confirm_reg + 3'd1;
        end
    end

    // State register
    always_ff @(posedge clock) begin
        if (restart) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        if (!enable) begin
            state_next = ST_IDLE;
        end else begin
            unique case (state_reg)
                ST_IDLE:      state_next = ST_MEDIR;
                ST_MEDIR:     state_next = ST_ESPERA;
                ST_ESPERA: begin
                    if (both_seen) begin
                        state_next = ST_AVALIA;
                    end else if (timer_reg == TIMEOUT_LAST) begin
                        state_next = ST_FALHA;
                    end
                end
                ST_AVALIA:    state_next = ST_INTERVALO;
                ST_INTERVALO: begin
                    if (timer_reg == PERIOD_LAST) begin
                        state_next = ST_MEDIR;
                    end
                end
                ST_FALHA:     state_next = ST_INTERVALO;
                default:      state_next = ST_IDLE;
            endcase
        end
    end

    // Output and datapath next-value logic
    always_comb begin
        timer_next     = 26'd0;
        got_esq_next   = got_esq_reg;
        got_dir_next   = got_dir_reg;
        confirm_next   = confirm_reg;
        prev_next      = prev_reg;
        direction_next = direction_reg;
        timeouts_next  = timeouts_reg;
        turn           = 1'b0;
        if (state_next == state_reg && state_reg != ST_IDLE) begin
            timer_next = timer_reg + 26'd1;
        end
        if (!enable) begin
            confirm_next = 3'd0;
            prev_next    = VERD_NONE;
        end else begin
            case (state_reg)
                ST_MEDIR: begin
                    got_esq_next = 1'b0;
                    got_dir_next = 1'b0;
                end
                ST_ESPERA: begin
                    got_esq_next = got_esq_reg | pronto_esq;
                    got_dir_next = got_dir_reg | pronto_dir;
                    if (state_next == ST_FALHA) begin
                        timeouts_next = (timeouts_reg == 4'd15) ? 4'd15 : timeouts_reg + 4'd1;
                        confirm_next  = 3'd0;
                        prev_next     = VERD_NONE;
                    end
                end
                ST_AVALIA: begin
                    prev_next    = verdict;
                    confirm_next = confirm_eval;
                    if (confirm_eval >= CONFIRM_MIN && armed) begin
                        turn           = 1'b1;
                        confirm_next   = 3'd0;
                        direction_next = (verdict == VERD_RIGHT) ? direction_reg + 2'd1
                                                                 : direction_reg - 2'd1;
                    end
                end
                default: ;
            endcase
        end
        // A new game overrides any turn decided in the same cycle.
        if (clear_dir) begin
            confirm_next   = 3'd0;
            direction_next = 2'd0;
            turn           = 1'b0;
        end
        medir_next    = (state_next == ST_MEDIR);
        reset_if_next = (state_next == ST_FALHA);
    end

    always_ff @(posedge clock) begin
        if (restart) begin
            timer_reg     <= 26'd0;
            got_esq_reg   <= 1'b0;
            got_dir_reg   <= 1'b0;
            confirm_reg   <= 3'd0;
            prev_reg      <= VERD_NONE;
            direction_reg <= 2'd0;
            timeouts_reg  <= 4'd0;
            medir_reg     <= 1'b0;
            reset_if_reg  <= 1'b0;
            turned_reg    <= 1'b0;
        end else begin
            timer_reg     <= timer_next;
            got_esq_reg   <= got_esq_next;
            got_dir_reg   <= got_dir_next;
            confirm_reg   <= confirm_next;
            prev_reg      <= prev_next;
            direction_reg <= direction_next;
            timeouts_reg  <= timeouts_next;
            medir_reg     <= medir_next;
            reset_if_reg  <= reset_if_next;
            turned_reg    <= turn;
        end
    end

`ifdef SGA_TURN_LOCK_EN
    logic armed_reg;

    always_ff @(posedge clock) begin
        if (restart) begin
            armed_reg <= 1'b1;
        end else if (move_tick) begin
            armed_reg <= 1'b1;
        end else if (turn) begin
            armed_reg <= 1'b0;
        end
    end

    assign armed = armed_reg;
`else
    logic unused_move_tick;

    assign armed            = 1'b1;
    assign unused_move_tick = move_tick;
`endif

    assign medir           = medir_reg;
    assign reset_interface = reset_if_reg;
    assign direction       = direction_reg;
    assign turned          = turned_reg;
    assign timeout_count   = timeouts_reg;
    assign db_estado       = state_reg;

endmodule

// File: doc/sga_sensor_scheduler.md
# sga_sensor_scheduler

Sequences the two HC-SR04 ultrasonic interfaces (left and right) of the Snake Game Arcade datapath and turns their proximity verdicts into the 2-bit `direction` that drives head-position computation. It issues periodic `medir` pulses, waits for both `pronto` flags, recovers hung sensors through `reset_interface`, debounces the left/right decision over consecutive measurements, and applies at most one turn per snake move. It sits between the game control unit and the datapath's sensor/direction inputs.

## Interface

- `PERIOD`, default 400000: idle cycles between the end of one evaluation and the next `medir`. At 50 MHz this is 8 ms.
- `TIMEOUT`, default 2000000: maximum cycles spent waiting for both `pronto` flags before recovery.
- `CONFIRM`, default 2: number of consecutive identical non-neutral verdicts required to turn. Legal range is 1..7.
- `clock` input, 1 bit: system clock.
- `restart` input, 1 bit: synchronous, active-high reset.
- `enable` input, 1 bit: game in play; measurements run only while this is high.
- `clear_dir` input, 1 bit: new game; forces `direction` to 2'd0 (+X).
- `move_tick` input, 1 bit: one-cycle pulse each time the snake advances; re-arms turning.
- `pronto_esq` input, 1 bit: measurement-done pulse from the left interface.
- `pronto_dir` input, 1 bit: measurement-done pulse from the right interface.
- `esq` input, 1 bit: proximity verdict, left obstacle closer.
- `dir` input, 1 bit: proximity verdict, right obstacle closer.
- `medir` output, 1 bit: one-cycle start pulse to both interfaces.
- `reset_interface` output, 1 bit: one-cycle recovery pulse to both interfaces.
- `direction` output, 2 bits: 0 = +X, 1 = +Y, 2 = −X, 3 = −Y.
- `turned` output, 1 bit: one-cycle pulse when `direction` changes.
- `timeout_count` output, 4 bits: saturating count of sensor timeouts.
- `db_estado` output, 3 bits: current state encoding.

## Operation

- **States and encoding:** IDLE = 0, MEDIR = 1, ESPERA = 2, AVALIA = 3, INTERVALO = 4, FALHA = 5.
- **IDLE:** on `enable` = 1, go to MEDIR.
- **MEDIR:** assert `medir` for this cycle; clear the sticky flags `got_esq` and `got_dir`; clear the timer; go to ESPERA.
- **ESPERA:**
  - Set `got_esq` on `pronto_esq` and `got_dir` on `pronto_dir`. The flags are sticky, so the two pulses may arrive in any order or in the same cycle.
  - When both flags are set (including flags set this cycle), go to AVALIA.
  - Otherwise, when the timer reaches TIMEOUT−1, go to FALHA.
  - Both conditions in the same cycle: AVALIA wins.
- **AVALIA:** evaluate for one cycle, then go to INTERVALO.
  - Verdict: `esq` & ~`dir` = LEFT; `dir` & ~`esq` = RIGHT; otherwise NONE.
  - NONE, or a verdict different from the previous one: confirm counter = (verdict ≠ NONE ? 1 : 0).
  - Same non-neutral verdict as the previous one: increment the confirm counter, saturating at 7.
  - When the confirm counter (new value) is ≥ CONFIRM and `armed` = 1:
    - RIGHT sets `direction` ← `direction`+1 mod 4; LEFT sets `direction` ← `direction`−1 mod 4.
    - Pulse `turned`, clear `armed`, clear the confirm counter.
- **FALHA:** pulse `reset_interface`; increment `timeout_count`, saturating at 15; clear the confirm counter and the previous verdict; go to INTERVALO.
- **INTERVALO:** when the timer reaches PERIOD−1, go to MEDIR. The timer clears on every state entry.
- **`enable` = 0 in any state:** next state is IDLE; confirm counter and previous verdict are cleared. `direction`, `armed` and `timeout_count` are held. An in-flight measurement is discarded.
- **`armed`:**
  - Set by `move_tick`; cleared by a turn.
  - `move_tick` in the same cycle as a turn leaves `armed` = 1.
- **Priority on `direction`:** `restart` > `clear_dir` > turn. `clear_dir` also clears the confirm counter, and the turn in that cycle is suppressed.
- **Reset values** (while `restart` is high, and in the cycle after it):
  - state IDLE, `direction` = 0, `armed` = 1, confirm counter = 0, previous verdict NONE, timer = 0.
  - `medir`, `reset_interface` and `turned` = 0; `timeout_count` = 0; `db_estado` = 0.
- **Reset mid-operation:** return to IDLE on the next edge regardless of state; no `medir` or `reset_interface` pulse is emitted in that cycle.

## Timing

- All outputs are registered. `medir`, `reset_interface` and `turned` are high for exactly one cycle.
- IDLE → `medir` high: 1 cycle after `enable` is sampled high.
- Both `pronto` flags seen at edge k → AVALIA during cycle k+1 → `direction` and `turned` updated at edge k+2.
- Steady-state `medir` spacing: 1 (MEDIR) + ESPERA duration + 1 (AVALIA) + PERIOD cycles.
- Timeout: `reset_interface` is asserted TIMEOUT+1 cycles after `medir`, and the next `medir` follows PERIOD+1 cycles later.
- Timer width is 26 bits. PERIOD and TIMEOUT must both be ≥ 1.

## Configuration

- `SGA_TURN_LOCK_EN`:
  - Defined: one turn per `move_tick`, with the `armed` logic as above.
  - Undefined: `armed` is tied to 1 and `move_tick` is ignored, so every confirmed verdict turns, even several times within one move period.

## Test plan

Bench parameters: PERIOD = 10, TIMEOUT = 20, CONFIRM = 2, `SGA_TURN_LOCK_EN` defined.

1. **Reset:** `restart` for 2 cycles with `enable` = 1 → `direction` = 0, `timeout_count` = 0, `db_estado` = 0. The first `medir` appears 1 cycle after `restart` falls, and the next `medir` follows 1+wait+1+10 cycles later.
2. **Confirmed right turn:** two measurements with `dir` = 1, `esq` = 0; `pronto_esq` and `pronto_dir` 3 cycles apart → `direction` 0 → 1 with one `turned` pulse after the second AVALIA, none after the first.
3. **Turn lock:** four consecutive RIGHT verdicts with no `move_tick` → only one turn (`direction` = 1). Then pulse `move_tick` and give two more RIGHT verdicts → `direction` = 2. Two LEFT verdicts starting from `direction` = 0 → `direction` = 3 (wrap).
4. **Neutral and alternating verdicts:** verdict sequences RIGHT, NONE, RIGHT and then RIGHT, LEFT, RIGHT → no `turned` pulse; `direction` unchanged.
5. **Timeout:** only `pronto_esq` arrives → `reset_interface` pulses 21 cycles after `medir`, `timeout_count` = 1. Repeat 16 times → `timeout_count` stays at 15.
6. **Abort and priority:** drop `enable` during ESPERA → IDLE next cycle with no AVALIA. Assert `clear_dir` in the same cycle as a qualifying turn → `direction` = 0, no `turned` pulse.
